// File: rtl/fft_readout_sequencer_pkg.sv
// fft_readout_sequencer_pkg: shared FSM encoding, default index width and bit-reversal helper
package fft_readout_sequencer_pkg;
  localparam int MSB_DEFAULT = 8;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;
  // reverses the low w bits of x; bits at or above w come back as zero
  function automatic logic [15:0] bitrev(input logic [15:0] x, input int w);
    logic [15:0] r;
    r = '0;
    for (int k = 0; k < 16; k++) if (k < w) r[k] = x[4'(w - 1 - k)];
    return r;
  endfunction
endpackage

// File: rtl/fft_readout_sequencer_skid_fifo.sv
// readout_skid_fifo: two-entry FIFO absorbing RAM read latency, simultaneous push/pop when full
module readout_skid_fifo
  import fft_readout_sequencer_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic [1:0]        occupancy
);
  logic [DATA_W-1:0] mem0_q, mem0_d, mem1_q, mem1_d;
  logic [1:0] occ_q, occ_d, base;
  // pop shifts entry 1 forward, then push lands in the first free slot after that shift
  always_comb begin
    base = occ_q - {1'b0, pop};
    occ_d = base + {1'b0, push};
    mem0_d = (push && base == 2'd0) ? push_data : (pop ? mem1_q : mem0_q);
    mem1_d = (push && base == 2'd1) ? push_data : mem1_q;
  end
  // storage and occupancy registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem0_q <= '0;
      mem1_q <= '0;
      occ_q <= '0;
    end else begin
      mem0_q <= mem0_d;
      mem1_q <= mem1_d;
      occ_q <= occ_d;
    end
  end
  assign head = mem0_q;
  assign occupancy = occ_q;
endmodule

// File: rtl/fft_readout_sequencer.sv
// fft_readout_sequencer: reads FFT bins from bit-reversed RAM order and streams them in natural order
module fft_readout_sequencer
  import fft_readout_sequencer_pkg::*;
#(
  parameter int MSB    = MSB_DEFAULT,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [MSB-1:0]    rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [MSB-1:0]    out_index,
  output logic              out_last
);
  state_e state_q, state_d;
  logic [MSB:0] issue_cnt_q, issue_cnt_d;
  logic [MSB-1:0] out_cnt_q, out_cnt_d;
  logic inflight_q;
  logic [1:0] occupancy;
  logic pop;
  assign pop = out_valid & out_ready;
  assign out_valid = occupancy != 2'd0;
  assign out_index = out_cnt_q;
  assign out_last = out_valid && out_cnt_q == '1;
  assign busy = state_q == RUN || state_q == DRAIN;
  assign done = state_q == DONE;
  genvar k;
  for (k = 0; k < MSB; k++) begin : g_rev
    assign rd_addr[k] = issue_cnt_q[MSB-1-k];
  end
  // read credit, counter advance and FSM next state
  always_comb begin
    state_d = state_q;
    rd_en = state_q == RUN && ({1'b0, occupancy} + {2'b0, inflight_q} < 3'd2 + {2'b0, pop});
    issue_cnt_d = rd_en ? issue_cnt_q + 1'b1 : issue_cnt_q;
    out_cnt_d = pop ? out_cnt_q + 1'b1 : out_cnt_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = RUN;
        issue_cnt_d = '0;
        out_cnt_d = '0;
      end
      RUN:   if (issue_cnt_d[MSB]) state_d = DRAIN;
      DRAIN: if (pop && out_last) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end
  // state, counters and the in-flight read marker
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      issue_cnt_q <= '0;
      out_cnt_q <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q <= state_d;
      issue_cnt_q <= issue_cnt_d;
      out_cnt_q <= out_cnt_d;
      inflight_q <= rd_en;
    end
  end
  readout_skid_fifo #(.DATA_W(DATA_W)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight_q),
    .push_data (rd_data),
    .pop       (pop),
    .head      (out_data),
    .occupancy (occupancy)
  );
endmodule
